// File: rtl/seven_seg_scan_ctrl.sv
// Segment type and hex decoder shared by seven-segment display blocks,
// followed by the multiplexed scan controller that drives one shared
// segment bus across DIGIT_COUNT digits.

package seven_seg_pkg;
    // Bit order {g,f,e,d,c,b,a}; a 1 lights the segment.
    typedef logic [6:0] seven_seg_t;

    localparam seven_seg_t SEG_OFF = 7'h00;

    // Hex nibble to segment pattern (lower-case b and d keep them distinct from 8 and 0).
    function automatic seven_seg_t seven_seg(input logic [3:0] nib);
        seven_seg_t seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction
endpackage

// Scan controller: walks digits 0..DIGIT_COUNT-1, each preceded by an
// all-dark gap to avoid ghosting. New values wait in a one-entry buffer and
// become visible only when a frame starts at digit 0.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_COUNT        = 2,
    parameter int DWELL_CYCLES       = 1000,
    parameter int BLANK_CYCLES       = 16,
    parameter int LEADING_ZERO_BLANK = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [4*DIGIT_COUNT-1:0] din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output seven_seg_t               dout,
    output logic [DIGIT_COUNT-1:0]   digit_sel_n,
    output logic                     frame_done
);

    localparam int VW      = 4 * DIGIT_COUNT;
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGIT_COUNT - 1);
    localparam logic [DIGIT_COUNT-1:0] SEL_ONE = DIGIT_COUNT'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    // With no gap configured every digit goes straight to SHOW.
    localparam state_e FIRST_ST = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]   active_q, active_d;
    logic [VW-1:0]   pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    seven_seg_t      dout_q, dout_d;
    logic [DIGIT_COUNT-1:0] sel_n_q, sel_n_d;
    logic            frame_done_q, frame_done_d;

    logic            frame_start;
    logic            lit;
    logic            lz_blank;
    logic [3:0]      nib;

    assign din_ready   = !pend_full_q;
    assign dout        = dout_q;
    assign digit_sel_n = sel_n_q;
    assign frame_done  = frame_done_q;

    // Next state, counters and the pending/active value buffer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        frame_start = 1'b0;

        if (din_valid && !pend_full_q) begin
            pend_d      = din;
            pend_full_d = 1'b1;
        end

        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = FIRST_ST;
                    idx_d       = '0;
                    cnt_d       = '0;
                    frame_start = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = FIRST_ST;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d       = '0;
                            frame_start = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Pending is full here only when no capture happened this cycle.
        if (frame_start && pend_full_q) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
        end
    end

    // Display outputs derived from the next state so they register with it.
    always_comb begin
        lit          = (state_d == ST_SHOW);
        nib          = 4'(active_d >> (4 * idx_d));
        lz_blank     = (LEADING_ZERO_BLANK != 0) && (idx_d != '0) &&
                       ((active_d >> (4 * idx_d)) == '0);
        dout_d       = (lit && !lz_blank) ? seven_seg(nib) : SEG_OFF;
        sel_n_d      = lit ? ~(SEL_ONE << idx_d) : '1;
        frame_done_d = lit && (idx_d == IDX_LAST) && (cnt_d == DWELL_LAST);
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            dout_q       <= SEG_OFF;
            sel_n_q      <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            dout_q       <= dout_d;
            sel_n_q      <= sel_n_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
